// File: rtl/postcode_pkg.sv
// postcode_pkg: shared definitions for the POST-code pulse link.
//   state_t          - receive/transmit state of the pulse decoder
//   *_DEF            - default timing and sizing constants
//   bit_below()      - which txshift bit is driven on the edge leaving BITn
package postcode_pkg;

    localparam int REFCLK_FREQ_DEF   = 48_000_000;
    localparam int TIMER_MAX_DEF     = 480;        // 10 us at 48 MHz
    localparam int SYNC_STAGES_DEF   = 3;
    localparam int FIFO_DEPTH_DEF    = 16;
    localparam int IGNORE_PULSES_DEF = 4;

    // BIT7..BIT0 are consecutive so the next bit state is state+1,
    // and BIT0+1 lands on IGN.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P1     = 4'd1,
        S_P2     = 4'd2,
        S_P3     = 4'd3,
        S_INPOLL = 4'd4,
        S_BIT7   = 4'd5,
        S_BIT6   = 4'd6,
        S_BIT5   = 4'd7,
        S_BIT4   = 4'd8,
        S_BIT3   = 4'd9,
        S_BIT2   = 4'd10,
        S_BIT1   = 4'd11,
        S_BIT0   = 4'd12,
        S_IGN    = 4'd13
    } state_t;

    // Edge in BITn answers with txshift[n-1].
    function automatic logic [2:0] bit_below(state_t s);
        logic [2:0] idx;
        idx = 3'd0;
        case (s)
            S_BIT7:  idx = 3'd6;
            S_BIT6:  idx = 3'd5;
            S_BIT5:  idx = 3'd4;
            S_BIT4:  idx = 3'd3;
            S_BIT3:  idx = 3'd2;
            S_BIT2:  idx = 3'd1;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/post_fifo.sv
// post_fifo: synchronous FIFO, power-of-two depth.
//   clk, rst     - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  - write request and data
//   pop, rdata   - read request; rdata is the current head (valid when !empty)
//   count        - occupancy 0..DEPTH
//   full, empty  - status flags
// Pointers carry one extra bit so full and empty are told apart by the MSB.
module post_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // A pop frees the slot being written, so a full FIFO still accepts a
    // push in the same cycle; a pop on empty is simply dropped.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/postcode_fifo.sv
// postcode_fifo: POST-code pulse link between a target and a host.
//   refclk          - single clock
//   rst             - synchronous active-high reset
//   testreq         - async pulse train from the target
//   testack         - acknowledge back to the target (combinational)
//   rx_data/valid/ready - target->host bytes (FIFO head)
//   tx_data/valid/ready - host->target bytes (FIFO tail)
//   rx_count/tx_count   - FIFO occupancies
//   frame_err       - one-cycle pulse when a poll aborts a partial byte
// A burst of pulses ends after TIMER_MAX quiet ticks. 1 pulse = bit 1,
// 2 pulses = bit 0, 3 pulses = poll, 4 pulses = request a byte from the
// host which is then clocked out on testack one bit per further pulse.
module postcode_fifo
    import postcode_pkg::*;
#(
    parameter int REFCLK_FREQ   = REFCLK_FREQ_DEF,
    parameter int TIMER_MAX     = TIMER_MAX_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int RX_DEPTH      = FIFO_DEPTH_DEF,
    parameter int TX_DEPTH      = FIFO_DEPTH_DEF,
    parameter int IGNORE_PULSES = IGNORE_PULSES_DEF
) (
    input  logic                        refclk,
    input  logic                        rst,
    input  logic                        testreq,
    output logic                        testack,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        frame_err
);
    localparam int             TW       = $clog2(TIMER_MAX + 2);
    localparam logic [TW-1:0]  T_SAT    = TW'(TIMER_MAX + 1);
    localparam logic [TW-1:0]  T_END    = TW'(TIMER_MAX);
    localparam logic [2:0]     IGN_LAST = 3'(IGNORE_PULSES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || IGNORE_PULSES < 0 ||
        IGNORE_PULSES > 7 || REFCLK_FREQ <= 0) begin : g_param_err
        $error("postcode_fifo: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [TW-1:0]          timer;
    logic                   pulse_edge;
    logic                   burst_end;
    state_t                 state;
    logic                   ack_int;
    logic [2:0]             bit_cnt;
    logic [2:0]             ign_cnt;
    logic [7:0]             rxshift;
    logic [7:0]             txshift;
    logic [7:0]             tx_head;
    logic                   rx_push;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   tx_full;
    logic                   tx_empty;
    logic                   poll_fire;
    logic                   tx_take;

    // ---------------- synchroniser, edge and burst timer ----------------
    always_ff @(posedge refclk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], testreq};
    end

    assign pulse_edge = sync[SYNC_STAGES-2] && !sync[SYNC_STAGES-1];

    // Saturates one past TIMER_MAX so burst_end is a single-cycle event.
    always_ff @(posedge refclk) begin
        if (rst)                     timer <= T_SAT;
        else if (sync[SYNC_STAGES-2]) timer <= '0;
        else if (timer != T_SAT)     timer <= timer + TW'(1);
    end

    assign burst_end = (timer == T_END);

    // testack follows the synchronised pulse so the target only sees an
    // answer that was computed for this very pulse.
    assign testack   = testreq && ack_int && sync[SYNC_STAGES-1] && !rst;
    assign frame_err = pulse_edge && !burst_end && (state == S_P2) &&
                       (bit_cnt != 3'd0) && !rst;

    // Edges that offer the host's next byte; a byte is taken only if one waits.
    assign poll_fire = pulse_edge && !burst_end &&
                       ((state == S_P3) ||
                        (state == S_INPOLL && !ack_int) ||
                        (state == S_IGN && ign_cnt == IGN_LAST));
    assign tx_take   = poll_fire && !tx_empty;

    // ---------------- pulse decoder ----------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state   <= S_IDLE;
            ack_int <= 1'b0;
            bit_cnt <= 3'd0;
            ign_cnt <= 3'd0;
            rxshift <= 8'h00;
            txshift <= 8'h00;
            rx_push <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (burst_end) begin
                state <= S_IDLE;
                if (state == S_P1 || state == S_P2) begin
                    rxshift <= {rxshift[6:0], state == S_P1};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_push <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: if (pulse_edge) begin
                        state   <= S_P1;
                        ack_int <= 1'b1;
                    end
                    S_P1: if (pulse_edge) begin
                        state   <= S_P2;
                        ack_int <= 1'b1;
                    end
                    S_P2: if (pulse_edge) begin
                        state   <= S_P3;
                        ack_int <= !rx_full;
                        bit_cnt <= 3'd0;
                    end
                    S_P3: if (pulse_edge) begin
                        state   <= S_INPOLL;
                        ack_int <= !tx_empty;
                        if (tx_take) txshift <= tx_head;
                    end
                    S_INPOLL: if (pulse_edge) begin
                        if (ack_int) begin
                            state   <= S_BIT7;
                            ack_int <= txshift[7];
                        end else begin
                            ack_int <= !tx_empty;
                            if (tx_take) txshift <= tx_head;
                        end
                    end
                    S_BIT7, S_BIT6, S_BIT5, S_BIT4, S_BIT3, S_BIT2, S_BIT1:
                        if (pulse_edge) begin
                            ack_int <= txshift[bit_below(state)];
                            state   <= state_t'(state + 4'd1);
                        end
                    S_BIT0: if (pulse_edge) begin
                        state   <= S_IGN;
                        ack_int <= 1'b0;
                        ign_cnt <= 3'd0;
                    end
                    S_IGN: if (pulse_edge) begin
                        if (ign_cnt == IGN_LAST) begin
                            state   <= S_INPOLL;
                            ack_int <= !tx_empty;
                            if (tx_take) txshift <= tx_head;
                        end else begin
                            ign_cnt <= ign_cnt + 3'd1;
                            ack_int <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        ack_int <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- FIFOs ----------------
    post_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (refclk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_ready),
        .wdata (rxshift),
        .rdata (rx_data),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    post_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (refclk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .pop   (tx_take),
        .wdata (tx_data),
        .rdata (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign rx_valid = !rx_empty;
    assign tx_ready = !tx_full;

endmodule

// File: tb/tb_postcode_fifo.sv
// tb_postcode_fifo: directed + random bench for postcode_fifo. The model
// works at protocol level: a bit queue per byte, an RX byte queue and a TX
// byte queue, from which each pulse's expected acknowledge is derived.
module tb_postcode_fifo;
    localparam int TMAX = 40;
    localparam int RXD  = 4;
    localparam int TXD  = 4;
    localparam int IGN  = 4;
    localparam int SS   = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       testreq;
    logic       testack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [$clog2(RXD):0] rx_count;
    logic [$clog2(TXD):0] tx_count;
    logic       frame_err;

    int n_checks = 0;
    int n_err    = 0;
    int fe_cnt   = 0;

    byte unsigned rxq[$];
    byte unsigned txq[$];
    bit           bitq[$];

    postcode_fifo #(
        .REFCLK_FREQ(48_000_000), .TIMER_MAX(TMAX), .SYNC_STAGES(SS),
        .RX_DEPTH(RXD), .TX_DEPTH(TXD), .IGNORE_PULSES(IGN)
    ) dut (
        .refclk(refclk), .rst(rst), .testreq(testreq), .testack(testack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count), .frame_err(frame_err)
    );

    always #5 refclk = ~refclk;

    always @(negedge refclk) if (frame_err === 1'b1) fe_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic gap();
        cyc(TMAX + 10);
    endtask

    task automatic pulse_exp(input string tag, input logic e);
        logic a;
        testreq = 1'b1;
        cyc(5);
        a = testack;
        cyc(1);
        testreq = 1'b0;
        cyc(6);
        chk(tag, 32'(a), 32'(e));
    endtask

    // Protocol model: eight bits form a byte, MSB first on the wire.
    task automatic model_bit(input bit v);
        byte unsigned by;
        bitq.push_back(v);
        if (bitq.size() == 8) begin
            by = 8'h00;
            foreach (bitq[i]) by = {by[6:0], bitq[i]};
            if (rxq.size() < RXD) rxq.push_back(by);
            bitq.delete();
        end
    endtask

    task automatic send_bit(input bit v);
        pulse_exp("bit_ack", 1'b1);
        if (!v) pulse_exp("bit_ack", 1'b1);
        gap();
        model_bit(v);
    endtask

    task automatic send_byte(input byte unsigned b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic poll_head();
        int fe0;
        fe0 = fe_cnt;
        pulse_exp("poll_p1", 1'b1);
        pulse_exp("poll_p2", 1'b1);
        pulse_exp("poll_p3", rxq.size() < RXD);
        chk("frame_err", 32'(fe_cnt - fe0), 32'(bitq.size() != 0));
        bitq.delete();
    endtask

    task automatic input_bits();
        byte unsigned b;
        b = txq.pop_front();
        for (int i = 7; i >= 0; i--) pulse_exp("in_bit", b[i]);
    endtask

    task automatic tgt_poll(input bit inp);
        logic have;
        poll_head();
        if (inp) begin
            have = (txq.size() != 0);
            pulse_exp("poll_p4", have);
            if (have) input_bits();
        end
        gap();
    endtask

    task automatic host_push(input byte unsigned b);
        chk("tx_ready", 32'(tx_ready), 32'(txq.size() < TXD));
        tx_data  = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        if (txq.size() < TXD) txq.push_back(b);
        chk("tx_count", 32'(tx_count), 32'(txq.size()));
    endtask

    task automatic host_pop();
        chk("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
        if (rxq.size() != 0) chk("rx_data", 32'(rx_data), 32'(rxq[0]));
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        if (rxq.size() != 0) void'(rxq.pop_front());
        chk("rx_count", 32'(rx_count), 32'(rxq.size()));
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        bitq.delete();
    endtask

    initial begin
        byte unsigned b;
        int           r;
        rst = 1'b1; testreq = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        cyc(3);
        chk("rst_testack", 32'(testack), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0; testreq = 1'b0;
        cyc(TMAX + 10);

        // poll, then 0xA5 bit by bit; rx_valid rises two cycles after burst end
        tgt_poll(1'b0);
        b = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        pulse_exp("bit_ack", 1'b1);
        cyc(TMAX - 3);
        chk("rx_valid_early", 32'(rx_valid), 32'd0);
        cyc(1);
        chk("rx_valid_t2", 32'(rx_valid), 32'd1);
        chk("rx_data_a5", 32'(rx_data), 32'h0A5);
        model_bit(1'b1);
        gap();
        host_pop();
        host_pop();   // pop on empty is ignored

        // host byte 0x3C read by the target
        host_push(8'h3C);
        tgt_poll(1'b1);
        chk("tx_count_drained", 32'(tx_count), 32'd0);

        // empty TX: repeated pulse 4 unacked, then bytes arrive mid-burst;
        // after BIT0 and the ignored pulses the next pulse polls again
        poll_head();
        pulse_exp("p4_empty", 1'b0);
        pulse_exp("p4_retry", 1'b0);
        host_push(8'h81);
        host_push(8'h5A);
        pulse_exp("p4_ready", 1'b1);
        input_bits();
        pulse_exp("bit0_edge", 1'b0);
        for (int i = 0; i < IGN; i++) pulse_exp("ign_pulse", 1'b0);
        pulse_exp("repoll", txq.size() != 0);
        input_bits();
        gap();

        // TX fill past full
        for (int i = 0; i <= TXD; i++) host_push(8'($urandom));
        tgt_poll(1'b1);

        // RX fill: poll refused while full, accepted after one pop
        for (int i = 0; i < RXD; i++) send_byte(8'($urandom));
        chk("rx_full_count", 32'(rx_count), 32'(RXD));
        tgt_poll(1'b0);
        send_byte(8'($urandom));   // dropped
        host_pop();
        tgt_poll(1'b0);
        while (rxq.size() != 0) host_pop();

        // partial byte aborted by a poll, then a clean byte
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tgt_poll(1'b0);
        send_byte(8'hC6);
        host_pop();

        // reset mid-byte: no frame error afterwards
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1; cyc(2); rst = 1'b0; model_reset();
        tgt_poll(1'b0);

        // reset during BIT4 with testreq high
        send_byte(8'h66);
        host_push(8'hFF);
        poll_head();
        pulse_exp("p4_ready", 1'b1);
        void'(txq.pop_front());
        for (int i = 0; i < 4; i++) pulse_exp("in_bit", 1'b1);
        testreq = 1'b1;
        cyc(5);
        chk("bit3_ack", 32'(testack), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_testack_now", 32'(testack), 32'd0);
        cyc(2);
        chk("rst2_rx_count", 32'(rx_count), 32'd0);
        chk("rst2_tx_count", 32'(tx_count), 32'd0);
        chk("rst2_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst2_tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0; testreq = 1'b0; model_reset();
        cyc(10);
        tgt_poll(1'b1);

        // random mix against the model
        for (int k = 0; k < 25; k++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0: send_byte(8'($urandom));
                1: tgt_poll(1'b0);
                2: tgt_poll(1'b1);
                3: host_push(8'($urandom));
                default: host_pop();
            endcase
            chk("rnd_rx_count", 32'(rx_count), 32'(rxq.size()));
            chk("rnd_tx_count", 32'(tx_count), 32'(txq.size()));
        end
        while (rxq.size() != 0) host_pop();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
